two_dev_bus_arbiter: RTL and testbench
======================================

Name: two_dev_bus_arbiter

Overview:
- Sequential controller for the two-device shared N-bit bus multiplexer: it arbitrates `req_1`/`req_2` and drives the mux `sel` line plus one-hot grants.
- Round-robin fairness between the two devices, with a bounded tenure (`MAX_HOLD`) so a continuously requesting owner cannot starve the other.
- Sits beside the bus mux; its `sel` output connects directly to the mux select.

Parameters:
- `MAX_HOLD`, 4, maximum granted cycles per tenure while the other device is requesting. 0 = no preemption. Legal range 0..255.
- `CW`, 8, width of the tenure counter. Must satisfy 2^CW > `MAX_HOLD`.

Ports:
- `clk`  input  1  single system clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req_1`  input  1  device 1 requests the bus; level, held while it wants ownership.
- `req_2`  input  1  device 2 requests the bus.
- `gnt_1`  output  1  device 1 owns the bus; registered.
- `gnt_2`  output  1  device 2 owns the bus; registered.
- `sel`  output  1  mux select: 0 = device 1 drives, 1 = device 2 drives; registered.
- `busy`  output  1  `gnt_1` | `gnt_2`.
- `hold_cnt`  output  CW  current tenure length minus 1; 0 when idle.

Behaviour:
- States: IDLE, OWN1, OWN2. `gnt_1` = (state==OWN1), `gnt_2` = (state==OWN2).
- Internal `last_owner` bit records the most recently granted device.
- Reset values (asynchronous, applied immediately, including mid-tenure):
  - state = IDLE
  - `gnt_1` = `gnt_2` = 0, `busy` = 0
  - `sel` = 0
  - `hold_cnt` = 0
  - `last_owner` = 2, so device 1 wins the first contest.
- Latency: a request sampled high at edge t gives a grant visible after edge t, i.e. 1 cycle.
- Grants are never both high. There is no dead cycle between owners; the mux cannot contend.
- IDLE transitions:
  - Only `req_1` → OWN1; only `req_2` → OWN2.
  - Both → the device that is not `last_owner`.
  - Neither → stay IDLE.
- OWN1 transitions (OWN2 symmetric):
  - `req_1`=0 and `req_2`=1 → OWN2 (direct handover).
  - `req_1`=0 and `req_2`=0 → IDLE.
  - `req_1`=1, `req_2`=1, `MAX_HOLD`≠0 and `hold_cnt` ≥ `MAX_HOLD`-1 → OWN2 (preemption).
  - Otherwise stay OWN1.
- Contested owner: gets exactly `MAX_HOLD` granted cycles counted from tenure start. If the other request arrives late in a long tenure, the handover occurs at the next edge.
- `hold_cnt`:
  - 0 in the first granted cycle of a tenure.
  - +1 per further granted cycle, saturating at 2^CW-1.
  - Cleared to 0 on any ownership change or on entering IDLE.
  - Saturation must not block preemption.
- `sel`:
  - Updated on the same edge as the grants: 0 in OWN1, 1 in OWN2.
  - In IDLE it holds its previous value (parked on the last owner).
- `last_owner`: updated on every entry into OWN1 or OWN2.
- A preempted device keeps its request asserted. It regains the bus when the new owner releases or is itself preempted.
- Requests are assumed synchronous to `clk`. No internal synchronisers.

Test Plan:
1. Reset, then `req_1`=1 at cycle 2 → `gnt_1`=1, `sel`=0, `busy`=1 from cycle 3. `hold_cnt` = 0,1,2,… Drop `req_1` → `gnt_1`=0 next cycle, `sel` stays 0.
2. `req_1`=`req_2`=1 from IDLE after reset → `gnt_1` first. With `MAX_HOLD`=4:
   - `gnt_1` high exactly 4 cycles, then `gnt_2` for 4, then `gnt_1` again.
   - `sel` toggles 0→1→0 with the grants; never both grants high.
3. Device 2 owns, `req_1`=0; at `hold_cnt`=6 raise `req_1` with `req_2` held → handover to OWN1 on the next edge (late-arrival case). `hold_cnt` restarts at 0.
4. `MAX_HOLD`=0, both requesting, `req_1` first → `gnt_1` held 300 cycles. `hold_cnt` saturates at 255 with no preemption. Drop `req_1` → `gnt_2` the next cycle.
5. Owner device 2 releases while `req_1`=1 → `gnt_2`→0 and `gnt_1`→1 on the same edge, `sel`=0. Release both → IDLE, `sel` parks at 0. A later simultaneous request is granted to device 2 (`last_owner` = 1).
6. Assert `rst` mid-cycle during OWN2 with `hold_cnt`=2 → grants, `sel`, `busy` and `hold_cnt` go to 0 immediately without a clock edge. After release with both requesting → `gnt_1` first.

Source files
------------

// File: rtl/two_dev_bus_arbiter.sv
// rtl/two_dev_bus_arbiter.sv - round-robin arbiter with bounded tenure for a two-device shared bus mux
module two_dev_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int          CW       = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req_1,
  input  logic          i_req_2,
  output logic          o_gnt_1,
  output logic          o_gnt_2,
  output logic          o_sel,
  output logic          o_busy,
  output logic [CW-1:0] o_hold_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } state_t;

  // Last tenure cycle index at which a contested owner must hand over.
  localparam logic [CW-1:0] LP_LIMIT = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

  state_t        r_state;
  logic          r_gnt_1;
  logic          r_gnt_2;
  logic          r_sel;
  logic          r_last_owner;   // 0 = device 1, 1 = device 2
  logic [CW-1:0] r_hold_cnt;

  state_t        w_next_state;
  logic          w_preempt;

  // A saturated counter still satisfies the >= test, so preemption is never lost.
  assign w_preempt = (MAX_HOLD != 0) && (r_hold_cnt >= LP_LIMIT);

  // Next-owner decision: round-robin from IDLE, handover on release or tenure expiry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_req_1 && i_req_2) begin
          w_next_state = r_last_owner ? OWN1 : OWN2;
        end else if (i_req_1) begin
          w_next_state = OWN1;
        end else if (i_req_2) begin
          w_next_state = OWN2;
        end
      end
      OWN1: begin
        if (!i_req_1) begin
          w_next_state = i_req_2 ? OWN2 : IDLE;
        end else if (i_req_2 && w_preempt) begin
          w_next_state = OWN2;
        end
      end
      OWN2: begin
        if (!i_req_2) begin
          w_next_state = i_req_1 ? OWN1 : IDLE;
        end else if (i_req_1 && w_preempt) begin
          w_next_state = OWN1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State plus registered grants, select, owner history and tenure counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_gnt_1      <= 1'b0;
      r_gnt_2      <= 1'b0;
      r_sel        <= 1'b0;
      r_last_owner <= 1'b1;
      r_hold_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_gnt_1 <= (w_next_state == OWN1);
      r_gnt_2 <= (w_next_state == OWN2);
      if (w_next_state == OWN1) begin
        r_sel        <= 1'b0;
        r_last_owner <= 1'b0;
      end else if (w_next_state == OWN2) begin
        r_sel        <= 1'b1;
        r_last_owner <= 1'b1;
      end
      if ((w_next_state != IDLE) && (w_next_state == r_state)) begin
        if (r_hold_cnt != '1) begin
          r_hold_cnt <= r_hold_cnt + CW'(1);
        end
      end else begin
        r_hold_cnt <= '0;
      end
    end
  end

  assign o_gnt_1    = r_gnt_1;
  assign o_gnt_2    = r_gnt_2;
  assign o_sel      = r_sel;
  assign o_busy     = r_gnt_1 | r_gnt_2;
  assign o_hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_two_dev_bus_arbiter.sv
// tb/tb_two_dev_bus_arbiter.sv - directed scoreboard bench for two_dev_bus_arbiter
module tb_two_dev_bus_arbiter;

  logic       clk;
  logic       rst;
  logic       req_1a, req_2a, req_1b, req_2b;
  logic       gnt_1a, gnt_2a, sel_a, busy_a;
  logic       gnt_1b, gnt_2b, sel_b, busy_b;
  logic [7:0] hold_a, hold_b;

  two_dev_bus_arbiter #(.MAX_HOLD(4), .CW(8)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_req_1(req_1a), .i_req_2(req_2a),
    .o_gnt_1(gnt_1a), .o_gnt_2(gnt_2a), .o_sel(sel_a), .o_busy(busy_a),
    .o_hold_cnt(hold_a)
  );

  two_dev_bus_arbiter #(.MAX_HOLD(0), .CW(8)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_req_1(req_1b), .i_req_2(req_2b),
    .o_gnt_1(gnt_1b), .o_gnt_2(gnt_2b), .o_sel(sel_b), .o_busy(busy_b),
    .o_hold_cnt(hold_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        dut;
    logic [11:0] v;    // {gnt_1, gnt_2, sel, busy, hold_cnt}
  } exp_t;

  exp_t  sbq[$];
  string tagq[$];
  int    total;
  int    bad;

  task automatic push_exp(input logic d, input logic g1, input logic g2,
                          input logic s, input logic [7:0] h, input string tag);
    exp_t e;
    e.dut = d;
    e.v   = {g1, g2, s, g1 | g2, h};
    sbq.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic check_pop();
    exp_t        e;
    string       t;
    logic [11:0] obs;
    e = sbq.pop_front();
    t = tagq.pop_front();
    obs = e.dut ? {gnt_1b, gnt_2b, sel_b, busy_b, hold_b}
                : {gnt_1a, gnt_2a, sel_a, busy_a, hold_a};
    total++;
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", t, obs, e.v);
    end
  endtask

  // Drive requests, push the expectation, clock once, compare just after the edge.
  task automatic cyc(input logic d, input logic r1, input logic r2,
                     input logic g1, input logic g2, input logic s,
                     input logic [7:0] h, input string tag);
    if (d) begin
      req_1b = r1; req_2b = r2;
    end else begin
      req_1a = r1; req_2a = r2;
    end
    push_exp(d, g1, g2, s, h, tag);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  // Reset pulse started between edges; outputs must clear without a clock.
  task automatic pulse_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, tag);
    check_pop();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req_1a = 1'b0; req_2a = 1'b0; req_1b = 1'b0; req_2b = 1'b0;
    #12;
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "reset_a");
    check_pop();
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "reset_b");
    check_pop();
    rst = 1'b0;

    // 1: single requester, counting tenure, release keeps sel parked
    cyc(0, 0, 0, 0, 0, 0, 8'd0, "t1_idle");
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, 0, 0, 8'(i), "t1_own1");
    cyc(0, 0, 0, 0, 0, 0, 8'd0, "t1_release");

    // 2: both requesting from reset -> 4-cycle alternating tenures, device 1 first
    pulse_reset("t2_reset");
    for (int t = 0; t < 12; t++) begin
      if (((t / 4) % 2) == 0) cyc(0, 1, 1, 1, 0, 0, 8'(t % 4), "t2_rr_own1");
      else                    cyc(0, 1, 1, 0, 1, 1, 8'(t % 4), "t2_rr_own2");
    end
    cyc(0, 0, 0, 0, 0, 0, 8'd0, "t2_idle");

    // 3: late arrival of req_1 in a long device-2 tenure hands over next edge
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 1, 1, 8'(i), "t3_own2");
    cyc(0, 1, 1, 1, 0, 0, 8'd0, "t3_late_handover");
    cyc(0, 1, 1, 1, 0, 0, 8'd1, "t3_own1_cont");
    cyc(0, 0, 0, 0, 0, 0, 8'd0, "t3_idle");

    // 5: release handover, idle parking, round-robin from idle
    cyc(0, 0, 1, 0, 1, 1, 8'd0, "t5_own2");
    cyc(0, 1, 1, 0, 1, 1, 8'd1, "t5_own2_contested");
    cyc(0, 1, 0, 1, 0, 0, 8'd0, "t5_release_handover");
    cyc(0, 0, 0, 0, 0, 0, 8'd0, "t5_idle_park");
    cyc(0, 1, 1, 0, 1, 1, 8'd0, "t5_rr_dev2");
    cyc(0, 1, 1, 0, 1, 1, 8'd1, "t6_own2_h1");
    cyc(0, 1, 1, 0, 1, 1, 8'd2, "t6_own2_h2");

    // 6: asynchronous reset mid-tenure, then device 1 wins the contest
    pulse_reset("t6_async_reset");
    cyc(0, 1, 1, 1, 0, 0, 8'd0, "t6_after_reset");
    cyc(0, 0, 0, 0, 0, 0, 8'd0, "t6_idle");

    // 4: MAX_HOLD=0 -> no preemption, counter saturates, release hands over
    cyc(1, 1, 0, 1, 0, 0, 8'd0, "t4_own1");
    for (int k = 1; k < 300; k++)
      cyc(1, 1, 1, 1, 0, 0, (k > 255) ? 8'd255 : 8'(k), "t4_no_preempt");
    cyc(1, 0, 1, 0, 1, 1, 8'd0, "t4_handover");
    cyc(1, 0, 0, 0, 0, 1, 8'd0, "t4_idle_park");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
